// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning path:
//   - btn_state_e : debounce FSM states
//   - DEF_*       : default timing constants (cycles at 100 MHz)
//   - cnt_width() : counter width wide enough for the largest timing constant
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    // One extra bit above $clog2 of the largest count so the saturation
    // value is never a legal compare target.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser bringing an asynchronous 1-bit input into clk.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (both flops clear to 0)
//   d     in  asynchronous input
//   q     out synchronised output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Metastability-settling flop pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises, debounces and edge-detects a raw push-button, giving a clean
// level plus one-cycle press/release pulses usable as a count enable.
// Optional macro: BTN_AUTO_REPEAT_EN -- adds auto-repeat press pulses while
// the button is held (REPEAT_DELAY then every REPEAT_PERIOD cycles).
// Ports:
//   clk           in  system clock
//   reset         in  asynchronous active-low reset
//   btn_in        in  raw bouncing button pin
//   btn_level     out debounced level
//   press_pulse   out one-cycle pulse on accepted press / auto-repeat
//   release_pulse out one-cycle pulse on accepted release
//   repeat_active out high while auto-repeat is running (0 without macro)
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          btn_sync;
    btn_state_e    state_r;
    logic [CW-1:0] db_cnt_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          repeat_fire_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // Debounce FSM with registered level and pulse outputs. Entering a WAIT
    // state loads 1 because that cycle's stable sample already counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            db_cnt_r  <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (btn_sync) begin
                        state_r  <= PRESS_WAIT;
                        db_cnt_r <= CW'(1);
                    end else begin
                        db_cnt_r <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state_r  <= IDLE;
                        db_cnt_r <= '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r  <= HELD;
                        db_cnt_r <= '0;
                        level_r  <= 1'b1;
                        press_r  <= 1'b1;
                    end else begin
                        db_cnt_r <= sat_inc(db_cnt_r);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state_r  <= RELEASE_WAIT;
                        db_cnt_r <= CW'(1);
                    end else begin
                        db_cnt_r <= '0;
                        press_r  <= repeat_fire_s;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state_r  <= HELD;
                        db_cnt_r <= '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r   <= IDLE;
                        db_cnt_r  <= '0;
                        level_r   <= 1'b0;
                        release_r <= 1'b1;
                    end else begin
                        db_cnt_r <= sat_inc(db_cnt_r);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    db_cnt_r <= '0;
                    level_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] hold_cnt_r;
    logic          rep_r;
    logic          accept_release_s;

    assign accept_release_s = (state_r == RELEASE_WAIT) && !btn_sync && (db_cnt_r == DB_LAST);
    // Hold counter only advances in HELD with the button still down; the
    // first target is the initial delay, later targets the repeat period.
    assign repeat_fire_s = (state_r == HELD) && btn_sync &&
                           (rep_r ? (hold_cnt_r == PER_LAST) : (hold_cnt_r == DLY_LAST));

    // Auto-repeat hold timer; frozen while a release is being debounced so
    // a release glitch does not restart the repeat timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_r <= '0;
            rep_r      <= 1'b0;
        end else if ((state_r == HELD) && btn_sync) begin
            if (repeat_fire_s) begin
                hold_cnt_r <= '0;
                rep_r      <= 1'b1;
            end else begin
                hold_cnt_r <= sat_inc(hold_cnt_r);
            end
        end else if ((state_r == IDLE) || accept_release_s) begin
            hold_cnt_r <= '0;
            rep_r      <= 1'b0;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign repeat_active = rep_r;
`else
    assign repeat_fire_s = 1'b0;
    assign repeat_active = 1'b0;
`endif

    assign btn_level     = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Expectations follow the macro
// BTN_AUTO_REPEAT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_active;

    int n_cmp;
    int n_err;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_active (repeat_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n edges; edge 1 is the first edge sampling the current btn_in.
    // p_at: accepted press edge (or -1); r_at: release edge (or -1);
    // rep_on: repeat_active already high when the window starts.
    task automatic watch(input string tag, input int n, input int p_at, input int r_at, input bit rep_on);
        bit exp_p;
        bit exp_r;
        bit exp_a;
        for (int i = 1; i <= n; i++) begin
            step();
            exp_p = (i == p_at);
            if (AUTO && p_at > 0 && i >= p_at + RD && ((i - p_at - RD) % RP) == 0)
                exp_p = 1'b1;
            exp_r = (i == r_at);
            exp_a = AUTO && ((rep_on && (r_at < 0 || i < r_at)) || (p_at > 0 && i >= p_at + RD));
            check_eq($sformatf("%s_press@%0d", tag, i), {31'd0, press_pulse}, {31'd0, exp_p});
            check_eq($sformatf("%s_release@%0d", tag, i), {31'd0, release_pulse}, {31'd0, exp_r});
            check_eq($sformatf("%s_rep@%0d", tag, i), {31'd0, repeat_active}, {31'd0, exp_a});
        end
    endtask

    initial begin
        bit pat [9];
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        btn_in = 1'b0;
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state.
        step();
        step();
        check_eq("rst_level", {31'd0, btn_level}, 32'd0);
        check_eq("rst_press", {31'd0, press_pulse}, 32'd0);
        check_eq("rst_release", {31'd0, release_pulse}, 32'd0);
        check_eq("rst_rep", {31'd0, repeat_active}, 32'd0);
        reset = 1'b1;

        // Idle with button low: nothing happens.
        watch("idle", 20, -1, -1, 1'b0);
        check_eq("idle_level", {31'd0, btn_level}, 32'd0);

        // Clean press: pulse on the 6th edge (N+5).
        btn_in = 1'b1;
        watch("press", 8, 6, -1, 1'b0);
        check_eq("press_level", {31'd0, btn_level}, 32'd1);

        // Clean release.
        btn_in = 1'b0;
        watch("release", 8, -1, 6, 1'b0);
        check_eq("release_level", {31'd0, btn_level}, 32'd0);

        // Short glitches of 1..3 cycles give no pulse.
        for (int g = 1; g <= 3; g++) begin
            btn_in = 1'b1;
            for (int k = 0; k < g; k++) step();
            btn_in = 1'b0;
            watch($sformatf("glitch%0d", g), 8, -1, -1, 1'b0);
            check_eq($sformatf("glitch%0d_level", g), {31'd0, btn_level}, 32'd0);
        end

        // Bouncy press 1,0,1,1,0,1,1,1,1: pattern sampled at edges M..M+8,
        // last 0->1 at M+5, so the press lands at M+10.
        for (int j = 0; j < 9; j++) begin
            btn_in = pat[j];
            step();
            check_eq($sformatf("bounce_press@%0d", j), {31'd0, press_pulse}, 32'd0);
        end
        watch("bounce_tail", 4, 2, -1, 1'b0);
        check_eq("bounce_level", {31'd0, btn_level}, 32'd1);

        // Reset for one cycle while HELD: level drops asynchronously, then a
        // full debounce of the still-held button is needed.
        reset = 1'b0;
        #1;
        check_eq("async_rst_level", {31'd0, btn_level}, 32'd0);
        step();
        reset = 1'b1;
        watch("after_rst", 8, 6, -1, 1'b0);
        check_eq("after_rst_level", {31'd0, btn_level}, 32'd1);

        // Two-cycle release bounce while HELD: no release.
        btn_in = 1'b0;
        step();
        check_eq("rel_bounce_a", {31'd0, release_pulse}, 32'd0);
        step();
        check_eq("rel_bounce_b", {31'd0, release_pulse}, 32'd0);
        btn_in = 1'b1;
        watch("rel_bounce", 4, -1, -1, 1'b0);
        check_eq("rel_bounce_level", {31'd0, btn_level}, 32'd1);

        btn_in = 1'b0;
        watch("rel2", 8, -1, 6, 1'b0);
        check_eq("rel2_level", {31'd0, btn_level}, 32'd0);

        // Long hold: single pulse, or auto-repeat at t0+10, t0+15, ...
        btn_in = 1'b1;
        watch("hold", 46, 6, -1, 1'b0);
        check_eq("hold_level", {31'd0, btn_level}, 32'd1);
        btn_in = 1'b0;
        watch("hold_rel", 8, -1, 6, AUTO);
        check_eq("hold_rel_level", {31'd0, btn_level}, 32'd0);
        check_eq("hold_rel_rep", {31'd0, repeat_active}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
